lsu_align_unit: RTL
===================

Name: lsu_align_unit

Overview:
- Parametrised load/store alignment unit between the execute stage and a word-organised data memory.
- Handles byte, halfword and word loads/stores at any byte address.
- Generates byte enables and lane-shifted write data, then sign- or zero-extends load data.
- Accesses that cross a word boundary are split into two sequential aligned memory beats, or rejected with an error, depending on a parameter.

Parameters:
- ADDR_W, 32, byte-address width; the word address is addr[ADDR_W-1:2].
- ALLOW_MISALIGNED, 1: 1 = split word-crossing accesses into two beats; 0 = flag any non-naturally-aligned access as an error with no memory traffic.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  access request.
- req_ready  out  1  unit idle, request accepted this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_mode  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LBU, 100 LHU, 101-111 = word.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, LSB-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misalignment error, valid with resp_valid.
- mem_req  out  1  memory beat request.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits always 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_gnt  in  1  memory accepted the beat.
- mem_rvalid  in  1  read data valid, at least 1 cycle after gnt.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, req_ready=1, all other outputs 0, beat buffer cleared. Reset mid-transaction abandons it: mem_req drops after that edge, no resp_valid is issued.
- States: IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP.
- Size: 1/2/4 bytes from req_mode (store 011 = byte, 100 = half). off = addr[1:0].
  - misaligned = (size=2 and off[0]) or (size=4 and off!=0).
  - cross = off+size>4.
- Acceptance: only when req_valid && req_ready. The unit latches we, mode, addr, wdata and goes to BEAT0.
  - Error path: if ALLOW_MISALIGNED=0 and misaligned, go to RESP with resp_err=1 and no mem_req.
  - Halfword at off=1 with ALLOW_MISALIGNED=1 is one beat.
- BEAT0 outputs:
  - mem_req=1, mem_addr={addr[ADDR_W-1:2],00}.
  - mem_be=(mask<<off)[3:0], where mask = 0001/0011/1111.
  - mem_wdata=(wdata<<8*off)[31:0].
  - Outputs are held stable until mem_gnt.
- After gnt in BEAT0:
  - store, !cross -> RESP;
  - store, cross -> BEAT1;
  - load -> WAIT0.
- WAIT0: on mem_rvalid, capture rdata into the low buffer, then go to BEAT1 if cross, else RESP.
- BEAT1 outputs:
  - mem_addr = word address + 4, wrapping modulo 2^ADDR_W.
  - mem_be=(mask>>(4-off)).
  - mem_wdata=wdata>>8*(4-off).
  - On gnt: store -> RESP, load -> WAIT1.
- WAIT1: on mem_rvalid, capture the high word and go to RESP.
- Load assembly: raw = ({hi,lo}>>8*off)[31:0], with hi=0 when single-beat. Then extend:
  - 000: sign-extend raw[7:0];
  - 001: sign-extend raw[15:0];
  - 011: zero-extend raw[7:0];
  - 100: zero-extend raw[15:0];
  - otherwise: raw.
- RESP: resp_valid=1 for exactly one cycle with registered rdata/err, then IDLE.
  - req_ready returns to 1 the following cycle; no back-to-back acceptance in RESP.
- Outputs are registered; mem_req is never asserted in the acceptance cycle.
- Minimum latency, aligned load with gnt immediate and rvalid one cycle later:
  - accept at cycle 0, mem_req at cycle 1, rvalid at cycle 2, resp_valid at cycle 3.
- mem_rvalid outside WAIT0/WAIT1 is ignored. mem_gnt outside BEAT0/BEAT1 is ignored.
- req_valid is ignored while req_ready=0; requests are not queued.

Test Plan:
- Reset, then LW at 0x100 with rdata 0xDEADBEEF -> mem_be=1111, mem_addr=0x100, resp_rdata=0xDEADBEEF, resp_valid 3 cycles after acceptance.
- LB at 0x103, rdata 0x80FF_0000 -> resp=0xFFFFFF80. Same access as LBU -> 0x00000080. LHU at 0x102 -> 0x000080FF.
- SH at 0x201, wdata 0x1234 -> one beat, mem_addr=0x200, be=0110, mem_wdata=0x00123400.
- LW at 0x303, ALLOW_MISALIGNED=1, words 0x44332211 at 0x300 and 0x88776655 at 0x304 -> two beats (be 1000 then 0111), resp=0x77665544.
- SW at 0x402, wdata 0xAABBCCDD, gnt delayed 3 cycles per beat -> beat0 be=1100 wdata=0xCCDD0000; beat1 addr 0x404 be=0011 wdata=0x0000AABB; outputs stable while waiting.
- ALLOW_MISALIGNED=0, LH at 0x001 -> no mem_req, resp_valid with resp_err=1, rdata 0. Separately, assert rst_n=0 during WAIT0 -> no resp_valid, req_ready=1 after reset.

Source files
------------

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit between the execute stage and a word-organised
// data memory. It turns byte/half/word accesses at any byte address into one
// or two aligned memory beats and extends the returned load data.
module lsu_align_unit #(
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_mode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_t;

    localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              we_q;
    logic [2:0]        mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    // Access size in bytes; the unsigned variants share sizes with the signed ones.
    function automatic logic [2:0] size_of(input logic [2:0] mode);
        case (mode)
            3'b000, 3'b011: size_of = 3'd1;
            3'b001, 3'b100: size_of = 3'd2;
            default:        size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] mask_of(input logic [2:0] mode);
        case (mode)
            3'b000, 3'b011: mask_of = 4'b0001;
            3'b001, 3'b100: mask_of = 4'b0011;
            default:        mask_of = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] off);
        logic [2:0] sz;
        sz = size_of(mode);
        is_misaligned = ((sz == 3'd2) && off[0]) || ((sz == 3'd4) && (off != 2'b00));
    endfunction

    // Selects the addressed bytes out of the {hi,lo} beat pair.
    function automatic logic [31:0] align_load(input logic [63:0] pair, input logic [1:0] off);
        logic [63:0] sh;
        sh = pair >> {off, 3'b000};
        align_load = sh[31:0];
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] mode, input logic [31:0] raw);
        case (mode)
            3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
            3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
            3'b011:  extend = {24'd0, raw[7:0]};
            3'b100:  extend = {16'd0, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    logic [1:0]        off_q;
    logic              cross_q;
    logic              err_in;
    logic [7:0]        be_pair;
    logic [63:0]       wdata_pair;
    logic [ADDR_W-3:0] word_q;

    assign off_q      = addr_q[1:0];
    assign cross_q    = ({2'b00, off_q} + {1'b0, size_of(mode_q)}) > 4'd4;
    assign err_in     = !ALLOW_MISALIGNED && is_misaligned(req_mode, req_addr[1:0]);
    // Lanes shifted past bit 3 / bit 31 belong to the second beat.
    assign be_pair    = {4'b0000, mask_of(mode_q)} << off_q;
    assign wdata_pair = {32'd0, wdata_q} << {off_q, 3'b000};
    assign word_q     = addr_q[ADDR_W-1:2];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state sequencing and output decode from the registered state.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = 4'b0000;
        mem_wdata  = 32'd0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = err_in ? RESP : BEAT0;
            end
            BEAT0: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {word_q, 2'b00};
                mem_be    = be_pair[3:0];
                mem_wdata = wdata_pair[31:0];
                if (mem_gnt) begin
                    if (we_q) state_d = cross_q ? BEAT1 : RESP;
                    else      state_d = WAIT0;
                end
            end
            WAIT0: begin
                if (mem_rvalid) state_d = cross_q ? BEAT1 : RESP;
            end
            BEAT1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {word_q + WORD_ONE, 2'b00};
                mem_be    = be_pair[7:4];
                mem_wdata = wdata_pair[63:32];
                if (mem_gnt) state_d = we_q ? RESP : WAIT1;
            end
            WAIT1: begin
                if (mem_rvalid) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, low-beat buffer and assembled response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            mode_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            lo_q    <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        mode_q  <= req_mode;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        lo_q    <= 32'd0;
                        rdata_q <= 32'd0;
                        err_q   <= err_in;
                    end
                end
                WAIT0: begin
                    if (mem_rvalid) begin
                        lo_q <= mem_rdata;
                        if (!cross_q)
                            rdata_q <= extend(mode_q, align_load({32'd0, mem_rdata}, off_q));
                    end
                end
                WAIT1: begin
                    if (mem_rvalid)
                        rdata_q <= extend(mode_q, align_load({mem_rdata, lo_q}, off_q));
                end
                default: ;
            endcase
        end
    end

endmodule
